regfile_wr_arb: RTL and testbench

Write-port arbiter and pending-register scoreboard for the ID-stage register file. It shares the register file's single write port between the in-order writeback stage and the long-latency unit (divider, multi-cycle loads). Long-latency results are buffered in a small FIFO. A starvation counter requests a pipeline bubble when those results wait too long. It sits between WB and the long-latency unit on one side and the register file write port on the other.

---
 rtl/regfile_wr_arb.sv | 126 ++++++++++++
 tb/tb_regfile_wr_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: WB always wins, long-latency results wait in a small FIFO.
// Optional pending-register scoreboard is built when REGFILE_WR_ARB_SCOREBOARD_EN is defined.
module regfile_wr_arb #(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int REGFILE_DEPTH      = 32,
    parameter int LL_FIFO_DEPTH      = 2,
    parameter int STARVE_LIMIT       = 4
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    input  logic                          wb_wr_en_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] wb_rd_addr_i,
    input  logic [REG_DATA_WIDTH-1:0]     wb_wr_data_i,
    input  logic                          ll_valid_i,
    output logic                          ll_ready_o,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ll_rd_addr_i,
    input  logic [REG_DATA_WIDTH-1:0]     ll_wr_data_i,
    input  logic                          ll_issue_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ll_issue_addr_i,
    output logic [REGFILE_DEPTH-1:0]      pend_vec_o,
    output logic                          stall_req_o,
    output logic                          rd_wr_en_o,
    output logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [REG_DATA_WIDTH-1:0]     rd_wr_data_o
);

    localparam int PTR_W = (LL_FIFO_DEPTH > 1) ? $clog2(LL_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [REGFILE_ADDR_WIDTH-1:0] fifo_addr [LL_FIFO_DEPTH];
    logic [REG_DATA_WIDTH-1:0]     fifo_data [LL_FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr, rd_ptr;
    logic [CNT_W-1:0]              count, count_next;
    logic [SC_W-1:0]               starve_cnt;
    logic                          ready_q, stall_q;
    logic                          head_valid, push, pop;
    logic [REGFILE_ADDR_WIDTH-1:0] head_addr;
    logic [REG_DATA_WIDTH-1:0]     head_data;

    assign head_valid = (count != '0);
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    // ready_q mirrors !full, so a full FIFO refuses pushes even while popping
    assign push       = ll_valid_i & ready_q;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    assign ll_ready_o  = ready_q;
    assign stall_req_o = stall_q;

    always_comb begin
        pop          = 1'b0;
        rd_wr_en_o   = 1'b0;
        rd_addr_o    = '0;
        rd_wr_data_o = '0;
        if (resetn_i) begin
            if (wb_wr_en_i) begin
                rd_wr_en_o   = (wb_rd_addr_i != '0);
                rd_addr_o    = wb_rd_addr_i;
                rd_wr_data_o = wb_wr_data_i;
            end else if (head_valid) begin
                // x0 heads are drained without a write
                pop          = 1'b1;
                rd_wr_en_o   = (head_addr != '0);
                rd_addr_o    = head_addr;
                rd_wr_data_o = head_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ll_rd_addr_i;
            fifo_data[wr_ptr] <= ll_wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ready_q    <= 1'b0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_next;
            ready_q <= (count_next != CNT_W'(LL_FIFO_DEPTH));
            if (head_valid && !pop) begin
                if (starve_cnt != SC_W'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + SC_W'(1);
                stall_q <= (starve_cnt == SC_W'(STARVE_LIMIT));
            end else begin
                starve_cnt <= '0;
                stall_q    <= 1'b0;
            end
        end
    end

`ifdef REGFILE_WR_ARB_SCOREBOARD_EN
    logic [REGFILE_DEPTH-1:0] pend_q, pend_next;

    // set is applied after clear so a same-cycle re-issue keeps the bit
    always_comb begin
        pend_next = pend_q;
        if (pop)        pend_next[head_addr]       = 1'b0;
        if (ll_issue_i) pend_next[ll_issue_addr_i] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) pend_q <= '0;
        else           pend_q <= pend_next;
    end

    assign pend_vec_o = pend_q;
`else
    logic unused_issue;
    assign unused_issue = ^{ll_issue_i, ll_issue_addr_i};
    assign pend_vec_o   = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb; inputs change 1ns after posedge, outputs sampled on negedge.
module tb_regfile_wr_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_wr_en;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_wr_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd_addr;
    logic [31:0] ll_wr_data;
    logic        ll_issue;
    logic [4:0]  ll_issue_addr;
    logic [31:0] pend_vec;
    logic        stall_req;
    logic        rd_wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wr_data;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_p9;

    always #5 clk = ~clk;

    regfile_wr_arb dut (
        .clk_i(clk), .resetn_i(resetn),
        .wb_wr_en_i(wb_wr_en), .wb_rd_addr_i(wb_rd_addr), .wb_wr_data_i(wb_wr_data),
        .ll_valid_i(ll_valid), .ll_ready_o(ll_ready),
        .ll_rd_addr_i(ll_rd_addr), .ll_wr_data_i(ll_wr_data),
        .ll_issue_i(ll_issue), .ll_issue_addr_i(ll_issue_addr),
        .pend_vec_o(pend_vec), .stall_req_o(stall_req),
        .rd_wr_en_o(rd_wr_en), .rd_addr_o(rd_addr), .rd_wr_data_o(rd_wr_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 0; wb_wr_en = 1; wb_rd_addr = 5'd3; wb_wr_data = 32'h11;
        ll_valid = 0; ll_rd_addr = 0; ll_wr_data = 0; ll_issue = 0; ll_issue_addr = 0;
        tick(); tick(); tick();
        @(negedge clk);
        checks++; if (ll_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ll_ready); end
        checks++; if (pend_vec !== 32'h0) begin failures++; $display("FAIL rst_pend got=%h exp=0", pend_vec); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_req); end
        checks++; if ({rd_wr_en, rd_addr, rd_wr_data} !== 38'h0) begin failures++;
            $display("FAIL rst_rd got=%b/%h/%h exp=0/0/0", rd_wr_en, rd_addr, rd_wr_data); end
        tick();
        resetn = 1; wb_wr_en = 0;
        tick();
        @(negedge clk);
        checks++; if (ll_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", ll_ready); end
        checks++; if (rd_wr_en !== 1'b0 || stall_req !== 1'b0) begin failures++;
            $display("FAIL rel_idle got=%b/%b exp=0/0", rd_wr_en, stall_req); end
        tick();
    endtask

    task automatic test_idle_drain();
        ll_valid = 1; ll_rd_addr = 5'd5; ll_wr_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (rd_wr_en !== 1'b0) begin failures++; $display("FAIL drain_c0 got=%b exp=0", rd_wr_en); end
        tick();
        ll_valid = 0;
        @(negedge clk);
        checks++; if (rd_wr_en !== 1'b1 || rd_addr !== 5'd5 || rd_wr_data !== 32'hDEADBEEF) begin failures++;
            $display("FAIL drain_wr got=%b/%0d/%h exp=1/5/deadbeef", rd_wr_en, rd_addr, rd_wr_data); end
        tick();
        @(negedge clk);
        checks++; if (rd_wr_en !== 1'b0 || ll_ready !== 1'b1) begin failures++;
            $display("FAIL drain_empty got=%b/%b exp=0/1", rd_wr_en, ll_ready); end
        tick();
    endtask

    task automatic test_priority();
        wb_wr_en = 1; wb_rd_addr = 5'd3; wb_wr_data = 32'h11;
        ll_valid = 1; ll_rd_addr = 5'd7; ll_wr_data = 32'h22;
        @(negedge clk);
        checks++; if (rd_wr_en !== 1'b1 || rd_addr !== 5'd3 || rd_wr_data !== 32'h11) begin failures++;
            $display("FAIL prio_c0 got=%b/%0d/%h exp=1/3/11", rd_wr_en, rd_addr, rd_wr_data); end
        tick();
        ll_valid = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++; if (rd_wr_en !== 1'b1 || rd_addr !== 5'd3) begin failures++;
                $display("FAIL prio_wb c%0d got=%b/%0d exp=1/3", i, rd_wr_en, rd_addr); end
            checks++; if (stall_req !== (i >= 6)) begin failures++;
                $display("FAIL prio_stall c%0d got=%b exp=%b", i, stall_req, (i >= 6)); end
            tick();
        end
        wb_wr_en = 0;
        @(negedge clk);
        checks++; if (rd_wr_en !== 1'b1 || rd_addr !== 5'd7 || rd_wr_data !== 32'h22 || stall_req !== 1'b1) begin
            failures++; $display("FAIL prio_ll got=%b/%0d/%h/%b exp=1/7/22/1", rd_wr_en, rd_addr, rd_wr_data, stall_req); end
        tick();
        @(negedge clk);
        checks++; if (stall_req !== 1'b0 || rd_wr_en !== 1'b0) begin failures++;
            $display("FAIL prio_clear got=%b/%b exp=0/0", stall_req, rd_wr_en); end
        tick();
    endtask

    task automatic test_full();
        wb_wr_en = 1; wb_rd_addr = 5'd3; wb_wr_data = 32'h11;
        ll_valid = 1; ll_rd_addr = 5'd10; ll_wr_data = 32'hA;
        tick();
        ll_rd_addr = 5'd11; ll_wr_data = 32'hB;
        @(negedge clk);
        checks++; if (ll_ready !== 1'b1) begin failures++; $display("FAIL full_one got=%b exp=1", ll_ready); end
        tick();
        ll_rd_addr = 5'd12; ll_wr_data = 32'hC;
        @(negedge clk);
        checks++; if (ll_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ll_ready); end
        tick();
        wb_wr_en = 0;
        @(negedge clk);
        checks++; if (ll_ready !== 1'b0 || rd_wr_en !== 1'b1 || rd_addr !== 5'd10 || rd_wr_data !== 32'hA) begin
            failures++; $display("FAIL full_pop1 got=%b/%b/%0d/%h exp=0/1/10/a", ll_ready, rd_wr_en, rd_addr, rd_wr_data); end
        tick();
        @(negedge clk);
        checks++; if (ll_ready !== 1'b1 || rd_addr !== 5'd11 || rd_wr_data !== 32'hB) begin
            failures++; $display("FAIL full_pop2 got=%b/%0d/%h exp=1/11/b", ll_ready, rd_addr, rd_wr_data); end
        tick();
        ll_valid = 0;
        @(negedge clk);
        checks++; if (rd_wr_en !== 1'b1 || rd_addr !== 5'd12 || rd_wr_data !== 32'hC) begin
            failures++; $display("FAIL full_held got=%b/%0d/%h exp=1/12/c", rd_wr_en, rd_addr, rd_wr_data); end
        tick();
        @(negedge clk);
        checks++; if (rd_wr_en !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", rd_wr_en); end
        tick();
    endtask

    task automatic test_x0();
        wb_wr_en = 1; wb_rd_addr = 5'd0; wb_wr_data = 32'h55;
        ll_valid = 1; ll_rd_addr = 5'd0; ll_wr_data = 32'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rd_wr_en !== 1'b0) begin failures++; $display("FAIL x0_c%0d got=%b exp=0", i, rd_wr_en); end
            tick();
            ll_valid = 0;
            if (i == 1) wb_wr_en = 0;
        end
        wb_wr_en = 1; ll_valid = 1; ll_rd_addr = 5'd4; ll_wr_data = 32'h44;
        tick();
        wb_wr_en = 0; ll_valid = 0;
        @(negedge clk);
        checks++; if (rd_wr_en !== 1'b1 || rd_addr !== 5'd4 || rd_wr_data !== 32'h44) begin failures++;
            $display("FAIL x0_popped got=%b/%0d/%h exp=1/4/44", rd_wr_en, rd_addr, rd_wr_data); end
        tick();
    endtask

    task automatic test_scoreboard();
        ll_issue = 1; ll_issue_addr = 5'd9;
        tick();
        ll_issue = 0; wb_wr_en = 1; wb_rd_addr = 5'd3; wb_wr_data = 32'h11;
        ll_valid = 1; ll_rd_addr = 5'd9; ll_wr_data = 32'h99;
        @(negedge clk);
        checks++; if (pend_vec !== exp_p9) begin failures++; $display("FAIL sb_set got=%h exp=%h", pend_vec, exp_p9); end
        tick();
        wb_wr_en = 0; ll_valid = 0;
        @(negedge clk);
        checks++; if (pend_vec !== exp_p9 || rd_addr !== 5'd9) begin failures++;
            $display("FAIL sb_popcyc got=%h/%0d exp=%h/9", pend_vec, rd_addr, exp_p9); end
        tick();
        ll_issue = 1; ll_issue_addr = 5'd0;
        @(negedge clk);
        checks++; if (pend_vec !== 32'h0) begin failures++; $display("FAIL sb_clear got=%h exp=0", pend_vec); end
        tick();
        ll_issue_addr = 5'd9;
        @(negedge clk);
        checks++; if (pend_vec !== 32'h0) begin failures++; $display("FAIL sb_x0 got=%h exp=0", pend_vec); end
        tick();
        ll_issue = 0; wb_wr_en = 1; ll_valid = 1; ll_rd_addr = 5'd9; ll_wr_data = 32'h98;
        tick();
        wb_wr_en = 0; ll_valid = 0; ll_issue = 1; ll_issue_addr = 5'd9;
        tick();
        ll_issue = 0;
        @(negedge clk);
        checks++; if (pend_vec !== exp_p9) begin failures++; $display("FAIL sb_setwins got=%h exp=%h", pend_vec, exp_p9); end
        tick();
    endtask

    task automatic test_reset_mid();
        wb_wr_en = 1; wb_rd_addr = 5'd3; wb_wr_data = 32'h11;
        ll_valid = 1; ll_rd_addr = 5'd20; ll_wr_data = 32'h20;
        tick();
        ll_rd_addr = 5'd21; ll_wr_data = 32'h21;
        tick();
        ll_valid = 0;
        for (int i = 2; i < 6; i++) tick();
        @(negedge clk);
        checks++; if (stall_req !== 1'b1 || ll_ready !== 1'b0) begin failures++;
            $display("FAIL mid_pre got=%b/%b exp=1/0", stall_req, ll_ready); end
        tick();
        resetn = 0;
        @(negedge clk);
        checks++; if ({rd_wr_en, rd_addr, rd_wr_data} !== 38'h0) begin failures++;
            $display("FAIL mid_rd got=%b/%h/%h exp=0/0/0", rd_wr_en, rd_addr, rd_wr_data); end
        tick();
        @(negedge clk);
        checks++; if (stall_req !== 1'b0 || ll_ready !== 1'b0 || pend_vec !== 32'h0 || rd_wr_en !== 1'b0) begin
            failures++; $display("FAIL mid_rst got=%b/%b/%h/%b exp=0/0/0/0", stall_req, ll_ready, pend_vec, rd_wr_en); end
        tick();
        resetn = 1; wb_wr_en = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rd_wr_en !== 1'b0) begin failures++; $display("FAIL mid_nowr c%0d got=%b exp=0", i, rd_wr_en); end
            tick();
        end
        @(negedge clk);
        checks++; if (ll_ready !== 1'b1 || stall_req !== 1'b0) begin failures++;
            $display("FAIL mid_rel got=%b/%b exp=1/0", ll_ready, stall_req); end
        tick();
    endtask

    initial begin
`ifdef REGFILE_WR_ARB_SCOREBOARD_EN
        exp_p9 = 32'h1 << 9;
`else
        exp_p9 = 32'h0;
`endif
        test_reset();
        test_idle_drain();
        test_priority();
        test_full();
        test_x0();
        test_scoreboard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
